hazard_scoreboard: RTL and testbench

Pipeline hazard controller for the five-stage IF/ID/EX/DM/WB datapath. The datapath has no forwarding, so this block keeps a per-register scoreboard of in-flight writes. It stalls the ID stage on read-after-write hazards and inserts bubbles into ID/EX. It squashes wrong-path instructions when EX resolves a taken branch, and it sequences a drain of the pipeline on request. It sits beside the decode stage: it drives the stall inputs of the PC, instruction memory and IF/ID register, and the clear input of ID/EX.

---
 rtl/hazard_scoreboard.sv | 151 +++++++++++++++
 tb/tb_hazard_scoreboard.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard controller for a forwarding-less five-stage pipeline: counts in-flight
// register writes, stalls ID on RAW/WAW hazards, squashes on taken branches, drains on request.
module hazard_scoreboard #(
    parameter int NREG  = 32,
    parameter int CNTW  = 2,
    parameter int PERFW = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_reg_write,
    input  logic [4:0]        id_rd,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_rd,
    input  logic              ex_branch_taken,
    input  logic              drain_req,
    output logic              stall,
    output logic              bubble,
    output logic              flush,
    output logic              issue,
    output logic              drained,
    output logic [NREG-1:0]   pending_mask,
    output logic [PERFW-1:0]  stall_count,
    output logic              sb_error
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_IDLE  = 2'd2;

    localparam logic [CNTW-1:0] CNT_FULL = '1;

    logic [CNTW-1:0]  cnt_reg [NREG];
    logic [CNTW-1:0]  cnt_next [NREG];
    logic [1:0]       state_reg, state_next;
    logic             sb_error_reg, sb_error_next;
    logic [PERFW-1:0] stall_count_reg, stall_count_next;

    logic             haz_rs, haz_rt, haz_waw, haz;
    logic             stall_c, bubble_c, flush_c, issue_c;
    logic             issue_write, retire_err;
    logic [NREG-1:0]  inc_vec, dec_vec, pending_vec;

    assign haz_rs  = id_uses_rs && (id_rs != 5'd0) && (cnt_reg[id_rs] != '0);
    assign haz_rt  = id_uses_rt && (id_rt != 5'd0) && (cnt_reg[id_rt] != '0);
    // A full counter has no room for another in-flight write to the same register.
    assign haz_waw = id_reg_write && (id_rd != 5'd0) && (cnt_reg[id_rd] == CNT_FULL);
    assign haz     = id_valid && (haz_rs || haz_rt || haz_waw);

    always_comb begin
        stall_c  = 1'b0;
        bubble_c = 1'b0;
        flush_c  = 1'b0;
        issue_c  = 1'b0;
        case (state_reg)
            ST_RUN: begin
                if (ex_branch_taken) begin
                    flush_c  = 1'b1;
                    bubble_c = 1'b1;
                end else if (haz) begin
                    stall_c  = 1'b1;
                    bubble_c = 1'b1;
                end else begin
                    issue_c  = id_valid;
                end
            end
            ST_DRAIN: begin
                stall_c  = 1'b1;
                bubble_c = 1'b1;
                flush_c  = ex_branch_taken;
            end
            default: begin
                stall_c  = 1'b1;
                bubble_c = 1'b1;
            end
        endcase
    end

    assign issue_write = issue_c && id_reg_write && (id_rd != 5'd0);
    assign retire_err  = wb_reg_write && (wb_rd != 5'd0) && (cnt_reg[wb_rd] == '0);

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            inc_vec[r]     = (r != 0) && issue_c && id_reg_write && (id_rd == 5'(r));
            dec_vec[r]     = (r != 0) && wb_reg_write && (wb_rd == 5'(r)) && (cnt_reg[r] != '0);
            pending_vec[r] = (cnt_reg[r] != '0);
            cnt_next[r]    = cnt_reg[r];
            if (inc_vec[r] && !dec_vec[r]) begin
                cnt_next[r] = cnt_reg[r] + CNTW'(1);
            end else if (dec_vec[r] && !inc_vec[r]) begin
                cnt_next[r] = cnt_reg[r] - CNTW'(1);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN: begin
                if (drain_req) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!drain_req) begin
                    state_next = ST_RUN;
                end else if ((pending_vec == '0) && !issue_write) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                if (!drain_req) state_next = ST_RUN;
            end
        endcase
    end

    assign sb_error_next    = sb_error_reg || retire_err;
    assign stall_count_next = (stall_c && (stall_count_reg != '1)) ?
                              stall_count_reg + PERFW'(1) : stall_count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_reg[r] <= '0;
            end
            state_reg       <= ST_RUN;
            sb_error_reg    <= 1'b0;
            stall_count_reg <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_reg[r] <= cnt_next[r];
            end
            state_reg       <= state_next;
            sb_error_reg    <= sb_error_next;
            stall_count_reg <= stall_count_next;
        end
    end

    // Gate the combinational controls so reset releases them without an edge.
    assign stall        = stall_c  && !reset;
    assign bubble       = bubble_c && !reset;
    assign flush        = flush_c  && !reset;
    assign issue        = issue_c  && !reset;
    assign drained      = (state_reg == ST_IDLE);
    assign pending_mask = pending_vec;
    assign stall_count  = stall_count_reg;
    assign sb_error     = sb_error_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against an array/queue based reference model.
`timescale 1ns/1ps
module tb_hazard_scoreboard;

    logic        clk, reset;
    logic        id_valid, id_uses_rs, id_uses_rt, id_reg_write;
    logic [4:0]  id_rs, id_rt, id_rd, wb_rd;
    logic        wb_reg_write, ex_branch_taken, drain_req;
    logic        stall, bubble, flush, issue, drained, sb_error;
    logic [31:0] pending_mask;
    logic [15:0] stall_count;

    hazard_scoreboard #(.NREG(32), .CNTW(2), .PERFW(16)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
        .id_rd(id_rd), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .ex_branch_taken(ex_branch_taken), .drain_req(drain_req), .stall(stall),
        .bubble(bubble), .flush(flush), .issue(issue), .drained(drained),
        .pending_mask(pending_mask), .stall_count(stall_count), .sb_error(sb_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: in-flight write counts per register, mode 0=run 1=drain 2=idle,
    // and a 3-deep pipeline of issued destinations that produces WB retires.
    int  m_cnt [32];
    int  m_mode, m_sc;
    bit  m_err;
    bit  pipe_v [3];
    int  pipe_rd [3];
    logic m_stall, m_bubble, m_flush, m_issue, m_haz;

    function automatic logic [31:0] exp_mask();
        logic [31:0] m;
        for (int r = 0; r < 32; r++) m[r] = (m_cnt[r] > 0);
        return m;
    endfunction

    always_comb begin
        m_stall  = 1'b0;
        m_bubble = 1'b0;
        m_flush  = 1'b0;
        m_issue  = 1'b0;
        m_haz    = id_valid &&
                   ((id_uses_rs && id_rs != 0 && m_cnt[id_rs] > 0) ||
                    (id_uses_rt && id_rt != 0 && m_cnt[id_rt] > 0) ||
                    (id_reg_write && id_rd != 0 && m_cnt[id_rd] == 3));
        if (!reset) begin
            if (m_mode == 0) begin
                if (ex_branch_taken)  begin m_flush = 1'b1; m_bubble = 1'b1; end
                else if (m_haz)       begin m_stall = 1'b1; m_bubble = 1'b1; end
                else                  m_issue = id_valid;
            end else if (m_mode == 1) begin
                m_stall = 1'b1; m_bubble = 1'b1; m_flush = ex_branch_taken;
            end else begin
                m_stall = 1'b1; m_bubble = 1'b1;
            end
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < 32; r++) m_cnt[r] <= 0;
            m_mode <= 0;
            m_err  <= 1'b0;
            m_sc   <= 0;
            for (int k = 0; k < 3; k++) begin
                pipe_v[k]  <= 1'b0;
                pipe_rd[k] <= 0;
            end
        end else begin
            for (int r = 1; r < 32; r++) begin
                m_cnt[r] <= m_cnt[r]
                    + ((m_issue && id_reg_write && int'(id_rd) == r) ? 1 : 0)
                    - ((wb_reg_write && int'(wb_rd) == r && m_cnt[r] > 0) ? 1 : 0);
            end
            if (wb_reg_write && wb_rd != 0 && m_cnt[wb_rd] == 0) m_err <= 1'b1;
            if (m_stall && m_sc < 65535) m_sc <= m_sc + 1;
            case (m_mode)
                0: if (drain_req) m_mode <= 1;
                1: if (!drain_req) m_mode <= 0;
                   else if (exp_mask() == 0 && !(m_issue && id_reg_write && id_rd != 0)) m_mode <= 2;
                default: if (!drain_req) m_mode <= 0;
            endcase
            pipe_v[2]  <= pipe_v[1];  pipe_rd[2] <= pipe_rd[1];
            pipe_v[1]  <= pipe_v[0];  pipe_rd[1] <= pipe_rd[0];
            pipe_v[0]  <= m_issue && id_reg_write;
            pipe_rd[0] <= int'(id_rd);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall",        64'(stall),        64'(m_stall));
            chk("bubble",       64'(bubble),       64'(m_bubble));
            chk("flush",        64'(flush),        64'(m_flush));
            chk("issue",        64'(issue),        64'(m_issue));
            chk("drained",      64'(drained),      64'(m_mode == 2));
            chk("pending_mask", 64'(pending_mask), 64'(exp_mask()));
            chk("stall_count",  64'(stall_count),  64'(m_sc));
            chk("sb_error",     64'(sb_error),     64'(m_err));
        end
    end

    // One pipeline cycle: drive ID/EX-side inputs, take WB from the pipeline model
    // (or a spurious retire when the WB slot is empty), return 3ns after the edge.
    task automatic cyc(input bit v, input logic [4:0] rs, input bit urs, input logic [4:0] rt,
                       input bit urt, input bit rw, input logic [4:0] rd, input bit br,
                       input bit dr, input bit inj, input logic [4:0] inj_rd);
        @(posedge clk);
        #1;
        id_valid = v; id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
        id_reg_write = rw; id_rd = rd; ex_branch_taken = br; drain_req = dr;
        if (pipe_v[2]) begin
            wb_reg_write = 1'b1; wb_rd = 5'(pipe_rd[2]);
        end else if (inj) begin
            wb_reg_write = 1'b1; wb_rd = inj_rd;
        end else begin
            wb_reg_write = 1'b0; wb_rd = 5'd0;
        end
        #2;
    endtask

    task automatic nop(input bit dr);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, dr, 0, 0);
    endtask

    task automatic wr(input logic [4:0] rd);
        cyc(1, 0, 0, 0, 0, 1, rd, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        id_reg_write = 0; id_rd = 0; wb_reg_write = 0; wb_rd = 0;
        ex_branch_taken = 0; drain_req = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #2;
    endtask

    bit drl;

    initial begin
        reset = 1'b1;
        id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        id_reg_write = 0; id_rd = 0; wb_reg_write = 0; wb_rd = 0;
        ex_branch_taken = 0; drain_req = 0;
        #2;
        chk_en = 1;
        do_reset();
        chk("rst_stall", 64'(stall), 64'(0));
        chk("rst_mask",  64'(pending_mask), 64'(0));
        chk("rst_sc",    64'(stall_count), 64'(0));
        chk("rst_drained", 64'(drained), 64'(0));

        // add r3, then sub r5,r3,r1: three stall cycles, issue after r3 retires
        wr(3);
        chk("raw_first_issue", 64'(issue), 64'(1));
        for (int k = 0; k < 3; k++) begin
            cyc(1, 3, 1, 1, 1, 1, 5, 0, 0, 0, 0);
            chk("raw_stall", 64'(stall), 64'(1));
        end
        cyc(1, 3, 1, 1, 1, 1, 5, 0, 0, 0, 0);
        chk("raw_issue", 64'(issue), 64'(1));
        chk("raw_sc", 64'(stall_count), 64'(3));
        chk("raw_mask3", 64'(pending_mask[3]), 64'(0));
        repeat (4) nop(0);

        // independent writes r1, r2, r4
        wr(1); chk("ind_stall1", 64'(stall), 64'(0));
        wr(2); chk("ind_stall2", 64'(stall), 64'(0));
        wr(4); chk("ind_stall4", 64'(stall), 64'(0));
        nop(0); chk("ind_mask_a", 64'(pending_mask), 64'(32'b10110));
        nop(0); chk("ind_mask_b", 64'(pending_mask), 64'(32'b10100));
        nop(0); chk("ind_mask_c", 64'(pending_mask), 64'(32'b10000));
        nop(0); chk("ind_mask_d", 64'(pending_mask), 64'(0));

        // hazard on r7 coinciding with a taken branch
        wr(7);
        cyc(1, 7, 1, 0, 0, 1, 8, 1, 0, 0, 0);
        chk("br_flush", 64'(flush), 64'(1));
        chk("br_bubble", 64'(bubble), 64'(1));
        chk("br_stall", 64'(stall), 64'(0));
        chk("br_issue", 64'(issue), 64'(0));
        nop(0);
        chk("br_sc", 64'(stall_count), 64'(3));
        chk("br_mask", 64'(pending_mask), 64'(32'h80));
        repeat (3) nop(0);

        // issue to r9 in the same cycle r9 retires
        wr(9); nop(0); nop(0);
        wr(9); chk("r9_issue", 64'(issue), 64'(1));
        nop(0); chk("r9_mask", 64'(pending_mask), 64'(32'h200));
        repeat (4) nop(0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd0);
        nop(0); chk("r0_err", 64'(sb_error), 64'(0));
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd12);
        nop(0); chk("underflow_err", 64'(sb_error), 64'(1));
        chk("underflow_mask", 64'(pending_mask), 64'(0));
        do_reset();
        chk("err_cleared", 64'(sb_error), 64'(0));

        // drain with two writes in flight
        wr(1); wr(2);
        nop(1);
        cyc(1, 0, 0, 0, 0, 1, 6, 0, 1, 0, 0);
        chk("drain_issue", 64'(issue), 64'(0));
        chk("drain_stall", 64'(stall), 64'(1));
        nop(1); nop(1);
        chk("drain_not_yet", 64'(drained), 64'(0));
        nop(1);
        chk("drain_idle", 64'(drained), 64'(1));
        nop(0);
        chk("drain_idle_hold", 64'(drained), 64'(1));
        nop(0);
        chk("drain_run", 64'(drained), 64'(0));

        // asynchronous reset in the middle of a stall
        wr(3);
        cyc(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("arst_pre_stall", 64'(stall), 64'(1));
        reset = 1'b1;
        #1;
        chk("arst_stall",  64'(stall), 64'(0));
        chk("arst_bubble", 64'(bubble), 64'(0));
        chk("arst_issue",  64'(issue), 64'(0));
        chk("arst_mask",   64'(pending_mask), 64'(0));
        chk("arst_sc",     64'(stall_count), 64'(0));
        do_reset();

        // randomized traffic against the model
        drl = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(29) == 0) drl = !drl;
            cyc(($urandom_range(3) != 0), 5'($urandom_range(7)), 1'($urandom_range(1)),
                5'($urandom_range(7)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                5'($urandom_range(7)), ($urandom_range(11) == 0), drl,
                ($urandom_range(149) == 0), 5'($urandom_range(7)));
        end
        repeat (5) nop(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
